// File: rtl/data_cache_responder.sv
// Direct-mapped, write-back, write-allocate data cache. Tag/data arrays sit in flops and are read
// combinationally; a four-state controller handles lookup, dirty writeback and line allocation.
module data_cache_responder #(
    parameter int S_INDEX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    input  logic         mem_read_d,
    input  logic         mem_write_d,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_wdata,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp_d,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [1:0]   state_dbg
);

    localparam int SETS  = 1 << S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WB     = 2'd2,
        ALLOC  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [SETS-1:0]  valid;
    logic [SETS-1:0]  dirty;
    logic [TAG_W-1:0] tags  [SETS];
    logic [255:0]     lines [SETS];

    logic [S_INDEX-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic [2:0]         word;
    logic [255:0]       cur_line;
    logic [31:0]        pre_word;
    logic [31:0]        merged_word;
    logic               hit;
    logic               write_hit;
    logic               fill_done;
    logic               wb_done;
    logic               unused_addr_bits;

    assign index            = mem_address[5 +: S_INDEX];
    assign tag              = mem_address[31 -: TAG_W];
    assign word             = mem_address[4:2];
    assign unused_addr_bits = ^mem_address[1:0];

    assign cur_line  = lines[index];
    assign pre_word  = cur_line[{word, 5'b0} +: 32];
    assign hit       = valid[index] && (tags[index] == tag);
    // A simultaneous read+write is a write; the read port still shows the pre-write word.
    assign write_hit = (state == LOOKUP) && hit && mem_write_d;
    assign fill_done = (state == ALLOC) && pmem_resp;
    assign wb_done   = (state == WB) && pmem_resp;

    always_comb begin
        merged_word = pre_word;
        for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) begin
                merged_word[b*8 +: 8] = mem_wdata[b*8 +: 8];
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (mem_read_d || mem_write_d) next_state = LOOKUP;
            end
            LOOKUP: begin
                if (hit)                               next_state = IDLE;
                else if (valid[index] && dirty[index]) next_state = WB;
                else                                   next_state = ALLOC;
            end
            WB: begin
                if (pmem_resp) next_state = ALLOC;
            end
            ALLOC: begin
                if (pmem_resp) next_state = LOOKUP;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_rdata    = '0;
        mem_resp_d   = 1'b0;
        pmem_address = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wdata   = '0;
        case (state)
            LOOKUP: begin
                if (hit) begin
                    mem_resp_d = 1'b1;
                    mem_rdata  = pre_word;
                end
            end
            WB: begin
                pmem_write   = 1'b1;
                pmem_address = {tags[index], index, 5'b0};
                pmem_wdata   = cur_line;
            end
            ALLOC: begin
                pmem_read    = 1'b1;
                pmem_address = {mem_address[31:5], 5'b0};
            end
            default: ;
        endcase
    end

    assign state_dbg = state;

    // Only the status bits are reset; a stale tag or line is harmless once its valid bit is clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            dirty <= '0;
        end else begin
            if (fill_done) begin
                valid[index] <= 1'b1;
                dirty[index] <= 1'b0;
            end
            if (wb_done) dirty[index] <= 1'b0;
            if (write_hit && (mem_byte_enable != 4'b0000)) dirty[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            lines[index] <= pmem_rdata;
            tags[index]  <= tag;
        end else if (write_hit) begin
            lines[index][{word, 5'b0} +: 32] <= merged_word;
        end
    end

endmodule

// File: tb/tb_data_cache_responder.sv
// Bench for data_cache_responder: directed scenarios followed by random traffic, checked against a
// flat byte-memory view plus a set-occupancy model that predicts every memory-side transfer.
module tb_data_cache_responder;

    logic         clk;
    logic         rst;
    logic [31:0]  mem_address;
    logic         mem_read_d;
    logic         mem_write_d;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_resp_d;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [1:0]   state_dbg;

    int tests = 0;
    int fails = 0;
    int wb_delay = 0;
    int fill_delay = 0;

    // Memory-side transfers as {is_write, address, data}; reads carry zero data.
    logic [288:0] exp_q [$];
    logic [288:0] got_q [$];

    logic [255:0] backing  [logic [26:0]];
    logic [255:0] ref_line [logic [26:0]];
    bit           m_present [8];
    bit           m_mod     [8];
    logic [26:0]  m_line    [8];

    data_cache_responder #(.S_INDEX(3)) dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read_d(mem_read_d), .mem_write_d(mem_write_d),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp_d(mem_resp_d),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .state_dbg(state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [255:0] init_line(input logic [26:0] ln);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) begin
            l[i*32 +: 32] = ({5'b0, ln} * 32'h9E37_79B1) ^ (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
        end
        return l;
    endfunction

    function automatic logic [255:0] get_backing(input logic [26:0] ln);
        return backing.exists(ln) ? backing[ln] : init_line(ln);
    endfunction

    function automatic logic [255:0] get_ref(input logic [26:0] ln);
        return ref_line.exists(ln) ? ref_line[ln] : init_line(ln);
    endfunction

    task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Memory responder: answers after the configured number of extra cycles, aborts on reset/drop.
    initial begin
        bit           r_wr;
        logic [31:0]  r_addr;
        logic [255:0] r_data;
        int           r_d;
        bit           r_abort;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            while (rst && (pmem_read || pmem_write)) begin
                r_wr    = pmem_write;
                r_addr  = pmem_address;
                r_data  = pmem_wdata;
                r_d     = r_wr ? wb_delay : fill_delay;
                r_abort = 1'b0;
                for (int i = 0; i < r_d; i++) begin
                    @(negedge clk);
                    if (!rst || !(pmem_read || pmem_write)) begin
                        r_abort = 1'b1;
                        break;
                    end
                end
                if (r_abort) break;
                if (r_wr) backing[r_addr[31:5]] = r_data;
                else      pmem_rdata = get_backing(r_addr[31:5]);
                pmem_resp = 1'b1;
                @(negedge clk);
                pmem_resp  = 1'b0;
                pmem_rdata = '0;
                got_q.push_back({r_wr, r_addr, r_wr ? r_data : 256'b0});
            end
        end
    end

    // Reset loses unwritten-back data, so the flat view reverts to what memory holds.
    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            if (m_present[s] && m_mod[s]) ref_line[m_line[s]] = get_backing(m_line[s]);
            m_present[s] = 1'b0;
            m_mod[s]     = 1'b0;
        end
    endtask

    task automatic run_req(input string name, input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata, output logic [31:0] rdata);
        logic [26:0]  ln;
        int           idx;
        int           w;
        bit           hit;
        int           exp_lat;
        int           lat;
        bit           got;
        logic [255:0] line;
        logic [31:0]  exp_rd;
        ln  = addr[31:5];
        idx = int'(ln % 8);
        w   = int'(addr[4:2]);
        exp_q.delete();
        got_q.delete();
        hit     = m_present[idx] && (m_line[idx] == ln);
        exp_lat = 2;
        if (!hit) begin
            if (m_present[idx] && m_mod[idx]) begin
                exp_q.push_back({1'b1, {m_line[idx], 5'b0}, get_ref(m_line[idx])});
                exp_lat += wb_delay + 1;
            end
            exp_q.push_back({1'b0, {ln, 5'b0}, 256'b0});
            exp_lat += fill_delay + 2;
            m_present[idx] = 1'b1;
            m_line[idx]    = ln;
            m_mod[idx]     = 1'b0;
        end
        line   = get_ref(ln);
        exp_rd = line[w*32 +: 32];
        if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) line[w*32 + b*8 +: 8] = wdata[b*8 +: 8];
            end
            ref_line[ln] = line;
            if (be != 4'b0000) m_mod[idx] = 1'b1;
        end

        @(negedge clk);
        mem_address     = addr;
        mem_read_d      = rd;
        mem_write_d     = wr;
        mem_byte_enable = be;
        mem_wdata       = wdata;
        lat   = 1;
        got   = 1'b0;
        rdata = '0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            lat++;
            if (mem_resp_d) begin
                got   = 1'b1;
                rdata = mem_rdata;
                check({name, "_pmem_idle_at_resp"}, {pmem_read, pmem_write}, 2'b00);
                break;
            end
        end
        check({name, "_resp_seen"}, got, 1'b1);
        if (got) begin
            check({name, "_latency"}, lat, exp_lat);
            if (rd) check({name, "_rdata"}, rdata, exp_rd);
            @(posedge clk);
            #1;
            check({name, "_resp_single_cycle"}, mem_resp_d, 1'b0);
        end
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        mem_byte_enable = '0;
        mem_wdata       = '0;
        check({name, "_xfer_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_xfer%0d", name, i), got_q[i], exp_q[i]);
        end
    endtask

    initial begin
        logic [31:0]  rd_val;
        logic [255:0] pre;
        logic [31:0]  a;
        int           op;
        bit           seen;

        rst = 1'b0;
        mem_address = '0;
        mem_read_d = 1'b0;
        mem_write_d = 1'b0;
        mem_byte_enable = '0;
        mem_wdata = '0;
        pre = init_line(27'h80);
        pre[63:32] = 32'hDEAD_BEEF;
        backing[27'h80]  = pre;
        ref_line[27'h80] = pre;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_resp", mem_resp_d, 1'b0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_pmem_read", pmem_read, 1'b0);
        check("rst_pmem_write", pmem_write, 1'b0);
        check("rst_pmem_address", pmem_address, 32'h0);
        check("rst_state", state_dbg, 2'd0);
        rst = 1'b1;

        // Cold read: fill after five cycles of pmem_read.
        fill_delay = 4;
        run_req("cold_read", 1'b1, 1'b0, 32'h0000_1004, 4'h0, 32'h0, rd_val);
        check("cold_read_value", rd_val, 32'hDEAD_BEEF);
        check("cold_read_fill_addr", got_q[0][287:256], 32'h0000_1000);

        run_req("hit_read", 1'b1, 1'b0, 32'h0000_1004, 4'h0, 32'h0, rd_val);
        check("hit_read_value", rd_val, 32'hDEAD_BEEF);

        run_req("hit_write", 1'b0, 1'b1, 32'h0000_1004, 4'b0101, 32'h1122_3344, rd_val);
        run_req("read_after_write", 1'b1, 1'b0, 32'h0000_1004, 4'h0, 32'h0, rd_val);
        check("merged_value", rd_val, 32'hDE22_BE44);

        // Conflict miss on a dirty line: writeback of the old line, then fill.
        wb_delay = 2;
        fill_delay = 1;
        run_req("dirty_evict", 1'b1, 1'b0, 32'h0000_2004, 4'h0, 32'h0, rd_val);
        check("dirty_evict_wb_is_write", got_q[0][288], 1'b1);
        check("dirty_evict_wb_addr", got_q[0][287:256], 32'h0000_1000);
        check("dirty_evict_wb_word1", got_q[0][63:32], 32'hDE22_BE44);
        check("dirty_evict_fill_addr", got_q[1][287:256], 32'h0000_2000);

        // Zero-enable write leaves the line clean, so eviction needs no writeback.
        run_req("zero_be_write", 1'b0, 1'b1, 32'h0000_2004, 4'b0000, 32'hFFFF_FFFF, rd_val);
        run_req("clean_evict", 1'b1, 1'b0, 32'h0000_3008, 4'h0, 32'h0, rd_val);
        check("clean_evict_only_fill", got_q.size(), 1);

        // Reset in the middle of a fill.
        fill_delay = 20;
        got_q.delete();
        @(negedge clk);
        mem_address = 32'h0000_5004;
        mem_read_d  = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (pmem_read) begin
                seen = 1'b1;
                break;
            end
        end
        check("abort_fill_started", seen, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_pmem_read_async", pmem_read, 1'b0);
        check("abort_pmem_address", pmem_address, 32'h0);
        check("abort_state", state_dbg, 2'd0);
        mem_read_d  = 1'b0;
        mem_address = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        check("abort_no_xfer", got_q.size(), 0);
        fill_delay = 1;
        run_req("post_reset_miss", 1'b1, 1'b0, 32'h0000_5004, 4'h0, 32'h0, rd_val);
        run_req("post_reset_hit", 1'b1, 1'b0, 32'h0000_5004, 4'h0, 32'h0, rd_val);

        // Read+write together behaves as a write returning the old word.
        run_req("rw_both", 1'b1, 1'b1, 32'h0000_5008, 4'b1111, 32'hCAFE_F00D, rd_val);
        run_req("rw_both_after", 1'b1, 1'b0, 32'h0000_5008, 4'h0, 32'h0, rd_val);
        check("rw_both_after_value", rd_val, 32'hCAFE_F00D);

        for (int i = 0; i < 60; i++) begin
            a = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 7)) << 5) |
                (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            op = $urandom_range(0, 3);
            wb_delay = $urandom_range(0, 3);
            fill_delay = $urandom_range(0, 3);
            run_req($sformatf("rnd%0d", i), op != 2, op >= 2, a, 4'($urandom_range(0, 15)),
                    $urandom, rd_val);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
